mem_bus_ctrl: RTL and testbench
===============================

MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 16: maximum REQ-state cycles waiting for bus_ack before abort.
REQ-002 The block SHALL have these ports:
- clk  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- MemWriteM  in  1  Memory-stage store request
- MemReadM  in  1  Memory-stage load request
- MByteM  in  1  1 = byte access, 0 = word access
- ALUResult  in  32  byte address from the core
- WriteData  in  32  store data from the core
- ReadData  out  32  registered load result to the core
- StallM  out  1  holds the core pipeline while an access is in flight
- bus_req  out  1  external bus request
- bus_we  out  1  1 = write cycle
- bus_addr  out  32  word-aligned address
- bus_wdata  out  32  write data
- bus_be  out  4  byte enables
- bus_ack  in  1  external completion strobe
- bus_rdata  in  32  external read data
- bus_err  out  1  sticky timeout flag

Function
REQ-003 The block SHALL implement a three-state FSM: IDLE, REQ, DONE.
REQ-004 In IDLE with MemReadM or MemWriteM at 1, the block SHALL assert StallM combinationally in that cycle, latch the bus fields, and go to REQ.
REQ-005 The block SHALL give a store priority when MemWriteM and MemReadM are both 1; the read SHALL be dropped.
REQ-006 bus_addr SHALL be {ALUResult[31:2],2'b00}.
REQ-007 For a word access, ALUResult[1:0] SHALL be ignored and bus_be SHALL be 4'hF.
REQ-008 For a byte access, bus_be SHALL be 4'b0001 << ALUResult[1:0].
REQ-009 For a byte store, bus_wdata SHALL be {4{WriteData[7:0]}}; for a word store it SHALL be WriteData.
REQ-010 In REQ, the block SHALL hold bus_req=1, bus_we (1 for a store) and StallM=1; bus_addr, bus_wdata, bus_be and bus_we SHALL stay stable until bus_ack is seen.
REQ-011 In REQ with bus_ack=1 on a load, the block SHALL capture ReadData at that edge:
- word: bus_rdata
- byte: the selected byte lane, zero-extended to 32 bits
It SHALL then go to DONE.
REQ-012 In REQ with bus_ack=1 on a store, the block SHALL go to DONE and leave ReadData unchanged.
REQ-013 bus_req SHALL be 0 in IDLE and DONE; bus_ack SHALL be ignored outside REQ.
REQ-014 In DONE, StallM SHALL be 0 so the core advances at that edge; the next state SHALL be IDLE unconditionally, with no re-issue.
REQ-015 Minimum latency: with bus_ack in the first REQ cycle, StallM=1 for exactly 2 cycles, then 0 in DONE.
REQ-016 ReadData SHALL hold its value until the next load completes.
REQ-017 A wait counter SHALL:
- clear on entry to REQ
- increment each REQ cycle without bus_ack
- when it reaches TIMEOUT_CYCLES, drop bus_req, set bus_err=1, load ReadData=32'h0 for a load, and go to DONE
REQ-018 If bus_ack arrives in the same cycle the counter reaches TIMEOUT_CYCLES, bus_ack SHALL win and bus_err SHALL be unchanged.
REQ-019 bus_err SHALL be sticky and cleared only by reset.

Reset
REQ-020 reset=0 SHALL immediately force the FSM to IDLE and set the following outputs, independent of clk:
- ReadData=0, StallM=0, bus_req=0, bus_we=0
- bus_addr=0, bus_wdata=0, bus_be=0, bus_err=0
- wait counter=0
REQ-021 Reset asserted mid-access SHALL drop bus_req in the same cycle, and the aborted access SHALL NOT be re-issued after reset release.
REQ-022 After reset release, the first access SHALL be accepted on the first rising edge with reset=1.

Verification
REQ-023 Word load: ALUResult=0x104, MemReadM=1, bus_ack on first REQ cycle with bus_rdata=0xCAFEBABE -> bus_addr=0x104, bus_be=F, StallM high 2 cycles, ReadData=0xCAFEBABE.
REQ-024 Byte store: ALUResult=0x203, WriteData=0x123456A5 -> bus_addr=0x200, bus_be=4'b1000, bus_wdata=0xA5A5A5A5, bus_we=1.
REQ-025 Byte load: ALUResult=0x11, bus_rdata=0x11223344 -> ReadData=0x00000033.
REQ-026 Timeout: no bus_ack, default parameter -> bus_req drops after 16 REQ cycles, bus_err=1 and stays set, ReadData=0, StallM falls in DONE.
REQ-027 Reset during REQ (bus_req=1): reset=0 between clock edges -> bus_req=0 and StallM=0 immediately; no request after release until a new MemReadM or MemWriteM.
REQ-028 Simultaneous MemReadM=MemWriteM=1 -> single write cycle (bus_we=1); ReadData unchanged.

Source files
------------

// File: rtl/mem_bus_ctrl_if.sv
// Core-side and external-bus signals of the memory bus controller.
// slave  : the controller's view (takes core requests, drives the bus).
// master : the environment's view (core plus memory/responder).
interface mem_bus_ctrl_if;
   // core side
   logic        MemWriteM;
   logic        MemReadM;
   logic        MByteM;
   logic [31:0] ALUResult;
   logic [31:0] WriteData;
   logic [31:0] ReadData;
   logic        StallM;
   // external bus side
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_be;
   logic        bus_ack;
   logic [31:0] bus_rdata;
   logic        bus_err;

   modport slave (
      input  MemWriteM, MemReadM, MByteM, ALUResult, WriteData, bus_ack, bus_rdata,
      output ReadData, StallM, bus_req, bus_we, bus_addr, bus_wdata, bus_be, bus_err
   );

   modport master (
      output MemWriteM, MemReadM, MByteM, ALUResult, WriteData, bus_ack, bus_rdata,
      input  ReadData, StallM, bus_req, bus_we, bus_addr, bus_wdata, bus_be, bus_err
   );
endinterface

// File: rtl/mem_bus_ctrl.sv
// Memory bus controller: turns a core load/store into one external bus
// cycle (IDLE -> REQ -> DONE), stalls the core meanwhile, aborts with a
// sticky error flag when the bus never acknowledges.
module mem_bus_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input logic           clk,
   input logic           reset,   // asynchronous, active low
   mem_bus_ctrl_if.slave bus
);

   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
   // last REQ cycle that may still complete; an un-acked one aborts
   localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] wait_q, wait_d;
   logic          req_q, req_d;
   logic          we_q, we_d;
   logic          byte_q, byte_d;
   logic [1:0]    off_q, off_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [3:0]    be_q, be_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          err_q, err_d;
   logic          stall_s;

   // Byte enables: one lane for a byte access, all four for a word.
   function automatic logic [3:0] be_f(input logic byte_i, input logic [1:0] off_i);
      if (byte_i) begin
         return 4'b0001 << off_i;
      end else begin
         return 4'hF;
      end
   endfunction

   // Store data: a byte store replicates the low byte onto every lane.
   function automatic logic [31:0] wdata_f(input logic byte_i, input logic [31:0] d_i);
      if (byte_i) begin
         return {4{d_i[7:0]}};
      end else begin
         return d_i;
      end
   endfunction

   // Load data: a byte load picks the addressed lane and zero-extends it.
   function automatic logic [31:0] rdata_f(input logic byte_i, input logic [1:0] off_i,
                                           input logic [31:0] d_i);
      logic [31:0] r;
      if (byte_i) begin
         case (off_i)
            2'd0:    r = {24'h000000, d_i[7:0]};
            2'd1:    r = {24'h000000, d_i[15:8]};
            2'd2:    r = {24'h000000, d_i[23:16]};
            2'd3:    r = {24'h000000, d_i[31:24]};
            default: r = 32'h00000000;
         endcase
      end else begin
         r = d_i;
      end
      return r;
   endfunction

   // Next-state and datapath-update logic of the access FSM.
   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      req_d   = req_q;
      we_d    = we_q;
      byte_d  = byte_q;
      off_d   = off_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      stall_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.MemReadM || bus.MemWriteM) begin
               // a store wins over a simultaneous load
               stall_s = 1'b1;
               state_d = ST_REQ;
               req_d   = 1'b1;
               wait_d  = '0;
               we_d    = bus.MemWriteM;
               byte_d  = bus.MByteM;
               off_d   = bus.ALUResult[1:0];
               addr_d  = {bus.ALUResult[31:2], 2'b00};
               be_d    = be_f(bus.MByteM, bus.ALUResult[1:0]);
               wdata_d = wdata_f(bus.MByteM, bus.WriteData);
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_REQ: begin
            stall_s = 1'b1;
            if (bus.bus_ack) begin
               // acknowledge wins even on the last permitted cycle
               if (!we_q) begin
                  rdata_d = rdata_f(byte_q, off_q, bus.bus_rdata);
               end else begin
                  rdata_d = rdata_q;
               end
               req_d   = 1'b0;
               state_d = ST_DONE;
            end else if (wait_q == WAIT_LAST) begin
               wait_d  = wait_q + CW'(1);
               req_d   = 1'b0;
               err_d   = 1'b1;
               if (!we_q) begin
                  rdata_d = 32'h00000000;
               end else begin
                  rdata_d = rdata_q;
               end
               state_d = ST_DONE;
            end else begin
               wait_d = wait_q + CW'(1);
            end
         end
         ST_DONE: begin
            // core advances on this edge; never re-issue
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            req_d   = 1'b0;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Bus fields, wait counter, load result and error flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wait_q  <= '0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         byte_q  <= 1'b0;
         off_q   <= 2'd0;
         addr_q  <= 32'h00000000;
         wdata_q <= 32'h00000000;
         be_q    <= 4'h0;
         rdata_q <= 32'h00000000;
         err_q   <= 1'b0;
      end else begin
         wait_q  <= wait_d;
         req_q   <= req_d;
         we_q    <= we_d;
         byte_q  <= byte_d;
         off_q   <= off_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // StallM is combinational so the core freezes in the request cycle;
   // gating with reset keeps it low while reset is held.
   assign bus.StallM    = stall_s & reset;
   assign bus.bus_req   = req_q;
   assign bus.bus_we    = we_q;
   assign bus.bus_addr  = addr_q;
   assign bus.bus_wdata = wdata_q;
   assign bus.bus_be    = be_q;
   assign bus.ReadData  = rdata_q;
   assign bus.bus_err   = err_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl: table of accesses with a bus
// responder, scoreboard of expected bus fields, plus reset sequences.
module tb_mem_bus_ctrl;

   localparam int TO = 16;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_err;

   mem_bus_ctrl_if bif ();

   mem_bus_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        re;
      logic        we;
      logic        byt;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          ack_dly;   // REQ cycle index carrying bus_ack; >= TO means never
      logic [31:0] e_addr;
      logic [3:0]  e_be;
      logic [31:0] e_wdata;
      logic        e_we;
      logic [31:0] e_rd;
      logic        e_err;
   } vec_t;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic        we;
   } exp_t;

   vec_t vecs[12];
   exp_t sb_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drop_inputs();
      bif.MemReadM  = 1'b0;
      bif.MemWriteM = 1'b0;
      bif.MByteM    = 1'b0;
      bif.bus_ack   = 1'b0;
   endtask

   // One access: issue in IDLE, play responder during REQ, check DONE.
   task automatic do_access(input int idx, input vec_t v);
      exp_t e;
      int   req_cycles;
      int   stalls;
      int   exp_req;
      bit   popped;
      @(negedge clk);
      bif.MemReadM  = v.re;
      bif.MemWriteM = v.we;
      bif.MByteM    = v.byt;
      bif.ALUResult = v.addr;
      bif.WriteData = v.wdata;
      bif.bus_rdata = v.rdata;
      bif.bus_ack   = 1'b0;
      sb_q.push_back('{v.e_addr, v.e_be, v.e_wdata, v.e_we});
      #1;
      chk($sformatf("v%0d_stall_idle", idx), {31'd0, bif.StallM}, 32'd1);
      stalls     = bif.StallM ? 1 : 0;
      req_cycles = 0;
      popped     = 1'b0;
      for (int c = 0; c < TO + 8; c++) begin
         @(negedge clk);
         if (!bif.bus_req) break;
         if (!popped) begin
            e = sb_q.pop_front();
            popped = 1'b1;
         end
         chk($sformatf("v%0d_addr", idx), bif.bus_addr, e.addr);
         chk($sformatf("v%0d_be", idx), {28'd0, bif.bus_be}, {28'd0, e.be});
         chk($sformatf("v%0d_we", idx), {31'd0, bif.bus_we}, {31'd0, e.we});
         if (e.we) chk($sformatf("v%0d_wdata", idx), bif.bus_wdata, e.wdata);
         if (bif.StallM) stalls++;
         bif.bus_ack = (req_cycles == v.ack_dly);
         req_cycles++;
      end
      bif.bus_ack = 1'b0;
      exp_req = (v.ack_dly < TO) ? v.ack_dly + 1 : TO;
      chk($sformatf("v%0d_req_seen", idx), {31'd0, popped}, 32'd1);
      chk($sformatf("v%0d_req_cycles", idx), req_cycles, exp_req);
      chk($sformatf("v%0d_stall_cycles", idx), stalls, exp_req + 1);
      chk($sformatf("v%0d_done_stall", idx), {31'd0, bif.StallM}, 32'd0);
      chk($sformatf("v%0d_rdata", idx), bif.ReadData, v.e_rd);
      chk($sformatf("v%0d_err", idx), {31'd0, bif.bus_err}, {31'd0, v.e_err});
      drop_inputs();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0;
      n_err    = 0;
      //             re    we    byt   addr        wdata         rdata        dly e_addr      e_be     e_wdata       e_we  e_rd          e_err
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h104,    32'h0,        32'hCAFEBABE, 0,  32'h104,    4'hF,    32'h0,        1'b0, 32'hCAFEBABE, 1'b0};
      vecs[1]  = '{1'b0, 1'b1, 1'b1, 32'h203,    32'h123456A5, 32'h0,        1,  32'h200,    4'b1000, 32'hA5A5A5A5, 1'b1, 32'hCAFEBABE, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 1'b1, 32'h11,     32'h0,        32'h11223344, 2,  32'h10,     4'b0010, 32'h0,        1'b0, 32'h00000033, 1'b0};
      vecs[3]  = '{1'b0, 1'b1, 1'b0, 32'h3F7,    32'hDEADBEEF, 32'h0,        0,  32'h3F4,    4'hF,    32'hDEADBEEF, 1'b1, 32'h00000033, 1'b0};
      vecs[4]  = '{1'b1, 1'b1, 1'b0, 32'h48,     32'h0BADF00D, 32'hFFFFFFFF, 0,  32'h48,     4'hF,    32'h0BADF00D, 1'b1, 32'h00000033, 1'b0};
      vecs[5]  = '{1'b1, 1'b0, 1'b1, 32'h402,    32'h0,        32'hA1B2C3D4, 3,  32'h400,    4'b0100, 32'h0,        1'b0, 32'h000000B2, 1'b0};
      vecs[6]  = '{1'b1, 1'b0, 1'b1, 32'h7,      32'h0,        32'h99887766, 0,  32'h4,      4'b1000, 32'h0,        1'b0, 32'h00000099, 1'b0};
      vecs[7]  = '{1'b0, 1'b1, 1'b1, 32'h1,      32'hFFFFFF3C, 32'h0,        0,  32'h0,      4'b0010, 32'h3C3C3C3C, 1'b1, 32'h00000099, 1'b0};
      vecs[8]  = '{1'b1, 1'b0, 1'b0, 32'h80,     32'h0,        32'h5555AAAA, 15, 32'h80,     4'hF,    32'h0,        1'b0, 32'h5555AAAA, 1'b0};
      vecs[9]  = '{1'b1, 1'b0, 1'b0, 32'h500,    32'h0,        32'h76543210, 99, 32'h500,    4'hF,    32'h0,        1'b0, 32'h00000000, 1'b1};
      vecs[10] = '{1'b0, 1'b1, 1'b1, 32'h502,    32'h00000077, 32'h0,        1,  32'h500,    4'b0100, 32'h77777777, 1'b1, 32'h00000000, 1'b1};
      vecs[11] = '{1'b1, 1'b0, 1'b0, 32'h600,    32'h0,        32'h13579BDF, 0,  32'h600,    4'hF,    32'h0,        1'b0, 32'h13579BDF, 1'b1};

      drop_inputs();
      bif.ALUResult = 32'h0;
      bif.WriteData = 32'h0;
      bif.bus_rdata = 32'h0;
      reset = 1'b0;
      #12;
      chk("rst_rdata", bif.ReadData, 32'h0);
      chk("rst_stall", {31'd0, bif.StallM}, 32'd0);
      chk("rst_req", {31'd0, bif.bus_req}, 32'd0);
      chk("rst_addr", bif.bus_addr, 32'h0);
      chk("rst_be", {28'd0, bif.bus_be}, 32'd0);
      chk("rst_err", {31'd0, bif.bus_err}, 32'd0);
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 12; i++) begin
         do_access(i, vecs[i]);
      end
      chk("sb_empty", sb_q.size(), 0);

      // bus_ack outside REQ must be ignored
      @(negedge clk);
      bif.bus_rdata = 32'hFFFFFFFF;
      bif.bus_ack   = 1'b1;
      @(negedge clk);
      bif.bus_ack   = 1'b0;
      chk("idle_ack_rdata", bif.ReadData, 32'h13579BDF);
      chk("idle_ack_req", {31'd0, bif.bus_req}, 32'd0);
      chk("idle_ack_stall", {31'd0, bif.StallM}, 32'd0);

      // reset asserted between edges in the middle of an access
      @(negedge clk);
      bif.MemReadM  = 1'b1;
      bif.ALUResult = 32'h900;
      @(negedge clk);
      @(negedge clk);
      chk("mid_req_before", {31'd0, bif.bus_req}, 32'd1);
      #2;
      reset = 1'b0;
      #1;
      chk("mid_rst_req", {31'd0, bif.bus_req}, 32'd0);
      chk("mid_rst_stall", {31'd0, bif.StallM}, 32'd0);
      chk("mid_rst_err", {31'd0, bif.bus_err}, 32'd0);
      chk("mid_rst_rdata", bif.ReadData, 32'h0);
      chk("mid_rst_addr", bif.bus_addr, 32'h0);
      drop_inputs();
      @(negedge clk);
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("no_reissue_%0d", k), {31'd0, bif.bus_req}, 32'd0);
      end

      // access presented at reset release is taken on the first edge
      @(negedge clk);
      reset = 1'b0;
      bif.MemWriteM = 1'b1;
      bif.MByteM    = 1'b0;
      bif.ALUResult = 32'hA0;
      bif.WriteData = 32'h00000011;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("rel_req", {31'd0, bif.bus_req}, 32'd1);
      chk("rel_addr", bif.bus_addr, 32'hA0);
      chk("rel_we", {31'd0, bif.bus_we}, 32'd1);
      bif.bus_ack = 1'b1;
      @(negedge clk);
      bif.bus_ack = 1'b0;
      chk("rel_done_stall", {31'd0, bif.StallM}, 32'd0);
      chk("rel_done_req", {31'd0, bif.bus_req}, 32'd0);
      drop_inputs();
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
